// File: rtl/core_pkg.sv
// Shared core definitions: register address width, forwarding select encoding
// and the forwarding-priority helper used by the hazard unit.
package core_pkg;

  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // The Memory-stage producer is younger than the Writeback one, so it wins.
  function automatic fwd_sel_t fwdSelect(
    input logic [REG_AW-1:0] srcE,
    input logic [REG_AW-1:0] wa3M,
    input logic [REG_AW-1:0] wa3W,
    input logic              regWriteM,
    input logic              regWriteW
  );
    if (regWriteM && (srcE == wa3M))      return FWD_M;
    else if (regWriteW && (srcE == wa3W)) return FWD_W;
    else                                  return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard interface between the control unit (master) and the hazard unit (slave).
interface hazard_if #(
  parameter int CNT_W = 16
);
  import core_pkg::*;

  logic [REG_AW-1:0] RA1D;
  logic [REG_AW-1:0] RA2D;
  logic [REG_AW-1:0] WA3D;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              PCWrPendingF;
  logic              PCSrcW;
  logic              BranchTakenE;
  logic              clr_cnt;

  fwd_sel_t          ForwardAE;
  fwd_sel_t          ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [CNT_W-1:0]  ldr_stall_cnt;
  logic [CNT_W-1:0]  br_flush_cnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
           PCWrPendingF, PCSrcW, BranchTakenE, clr_cnt,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           ldr_stall_cnt, br_flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
           PCWrPendingF, PCSrcW, BranchTakenE, clr_cnt,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           ldr_stall_cnt, br_flush_cnt
  );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline, with its
// own E/M/W register-address shadow and load-use / branch-flush event counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  logic [REG_AW-1:0] RA1E;
  logic [REG_AW-1:0] RA2E;
  logic [REG_AW-1:0] WA3E;
  logic [REG_AW-1:0] WA3M;
  logic [REG_AW-1:0] WA3W;
  logic              ldrStall;
  logic              flushE;

  always_comb begin
    ldrStall = hz.MemtoRegE & ((hz.RA1D == WA3E) | (hz.RA2D == WA3E));
    flushE   = ldrStall | hz.BranchTakenE;
  end

  always_comb begin
    hz.ForwardAE = fwdSelect(RA1E, WA3M, WA3W, hz.RegWriteM, hz.RegWriteW);
    hz.ForwardBE = fwdSelect(RA2E, WA3M, WA3W, hz.RegWriteM, hz.RegWriteW);
    hz.StallF    = ldrStall | hz.PCWrPendingF;
    hz.StallD    = ldrStall;
    hz.FlushD    = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
    hz.FlushE    = flushE;
  end

  // D -> E -> M -> W address shadow; E is never stalled, only flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RA1E <= '0;
      RA2E <= '0;
      WA3E <= '0;
      WA3M <= '0;
      WA3W <= '0;
    end else begin
      if (flushE) begin
        RA1E <= '0;
        RA2E <= '0;
        WA3E <= '0;
      end else begin
        RA1E <= hz.RA1D;
        RA2E <= hz.RA2D;
        WA3E <= hz.WA3D;
      end
      WA3M <= WA3E;
      WA3W <= WA3M;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uLdrCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ldrStall),
    .clr   (hz.clr_cnt),
    .count (hz.ldr_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uBrCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hz.BranchTakenE),
    .clr   (hz.clr_cnt),
    .count (hz.br_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus randomized traffic,
// checked every cycle against a queue-based model of instructions in E/M/W.
module tb_hazard_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) hz16 ();
  hazard_if #(.CNT_W(2))  hz2 ();

  assign hz2.RA1D         = hz16.RA1D;
  assign hz2.RA2D         = hz16.RA2D;
  assign hz2.WA3D         = hz16.WA3D;
  assign hz2.RegWriteM    = hz16.RegWriteM;
  assign hz2.RegWriteW    = hz16.RegWriteW;
  assign hz2.MemtoRegE    = hz16.MemtoRegE;
  assign hz2.PCWrPendingF = hz16.PCWrPendingF;
  assign hz2.PCSrcW       = hz16.PCSrcW;
  assign hz2.BranchTakenE = hz16.BranchTakenE;
  assign hz2.clr_cnt      = hz16.clr_cnt;

  hazard_unit #(.CNT_W(16)) uDut16 (.clk(clk), .reset(rst_n), .hz(hz16));
  hazard_unit #(.CNT_W(2))  uDut2  (.clk(clk), .reset(rst_n), .hz(hz2));

  int checks = 0;
  int errors = 0;

  // Model: instructions resident in E (index 0), M (1) and W (2).
  typedef struct {
    int ra1;
    int ra2;
    int wa3;
  } instr_t;
  instr_t pipe[3];
  int ldrEvents;
  int brEvents;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int modelLdr();
    return (hz16.MemtoRegE && ((int'(hz16.RA1D) == pipe[0].wa3) ||
                               (int'(hz16.RA2D) == pipe[0].wa3))) ? 1 : 0;
  endfunction

  function automatic int modelFwd(input int src);
    if (hz16.RegWriteM && src == pipe[1].wa3) return 2;
    if (hz16.RegWriteW && src == pipe[2].wa3) return 1;
    return 0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    ldrEvents = 0;
    brEvents  = 0;
  endtask

  task automatic checkAll();
    int ldr;
    int br;
    ldr = modelLdr();
    br  = hz16.BranchTakenE ? 1 : 0;
    chk("ForwardAE", int'(hz16.ForwardAE), modelFwd(pipe[0].ra1));
    chk("ForwardBE", int'(hz16.ForwardBE), modelFwd(pipe[0].ra2));
    chk("StallF", int'(hz16.StallF), (ldr == 1 || hz16.PCWrPendingF) ? 1 : 0);
    chk("StallD", int'(hz16.StallD), ldr);
    chk("FlushD", int'(hz16.FlushD),
        (hz16.PCWrPendingF || hz16.PCSrcW || hz16.BranchTakenE) ? 1 : 0);
    chk("FlushE", int'(hz16.FlushE), (ldr == 1 || br == 1) ? 1 : 0);
    chk("ldr_cnt16", int'(hz16.ldr_stall_cnt), minI(ldrEvents, 65535));
    chk("br_cnt16", int'(hz16.br_flush_cnt), minI(brEvents, 65535));
    chk("ldr_cnt2", int'(hz2.ldr_stall_cnt), minI(ldrEvents, 3));
    chk("br_cnt2", int'(hz2.br_flush_cnt), minI(brEvents, 3));
    chk("fwd2_mirror", int'(hz2.ForwardAE), modelFwd(pipe[0].ra1));
  endtask

  task automatic modelStep();
    int ldr;
    instr_t nxt;
    if (!rst_n) return;
    ldr = modelLdr();
    if (ldr == 1 || hz16.BranchTakenE)
      nxt = '{0, 0, 0};
    else
      nxt = '{int'(hz16.RA1D), int'(hz16.RA2D), int'(hz16.WA3D)};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
    if (hz16.clr_cnt) begin
      ldrEvents = 0;
      brEvents  = 0;
    end else begin
      ldrEvents += ldr;
      brEvents  += hz16.BranchTakenE ? 1 : 0;
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1 checkAll();
    modelStep();
    @(negedge clk);
  endtask

  task automatic setIn(input int ra1, input int ra2, input int wa3,
                       input bit rwm, input bit rww, input bit mem,
                       input bit pcw, input bit pcs, input bit bt, input bit clr);
    hz16.RA1D         = 4'(ra1);
    hz16.RA2D         = 4'(ra2);
    hz16.WA3D         = 4'(wa3);
    hz16.RegWriteM    = rwm;
    hz16.RegWriteW    = rww;
    hz16.MemtoRegE    = mem;
    hz16.PCWrPendingF = pcw;
    hz16.PCSrcW       = pcs;
    hz16.BranchTakenE = bt;
    hz16.clr_cnt      = clr;
  endtask

  task automatic zeroIn();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    modelReset();
    setIn($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ldr_cnt", int'(hz16.ldr_stall_cnt), 0);
    chk("rst_br_cnt", int'(hz16.br_flush_cnt), 0);
    @(negedge clk);

    zeroIn();
    rst_n = 1'b1;
    #1;
    chk("rst_fwdA", int'(hz16.ForwardAE), 0);
    chk("rst_fwdB", int'(hz16.ForwardBE), 0);
    chk("rst_StallF", int'(hz16.StallF), 0);
    chk("rst_StallD", int'(hz16.StallD), 0);
    chk("rst_FlushD", int'(hz16.FlushD), 0);
    chk("rst_FlushE", int'(hz16.FlushE), 0);
    cycle();

    // M-stage forward: producer R3, consumer right behind it
    zeroIn(); hz16.WA3D = 4'd3; cycle();
    zeroIn(); hz16.RA1D = 4'd3; hz16.RA2D = 4'd3; cycle();
    zeroIn(); hz16.RegWriteM = 1'b1;
    #1;
    chk("lit_fwdM_A", int'(hz16.ForwardAE), 2);
    chk("lit_fwdM_B", int'(hz16.ForwardBE), 2);
    cycle();

    // W-stage forward: one filler between producer and consumer
    zeroIn(); hz16.WA3D = 4'd3; cycle();
    zeroIn(); hz16.RA1D = 4'd7; hz16.RA2D = 4'd7; hz16.WA3D = 4'd9; cycle();
    zeroIn(); hz16.RA1D = 4'd3; hz16.RA2D = 4'd3; cycle();
    zeroIn(); hz16.RegWriteW = 1'b1;
    #1;
    chk("lit_fwdW_A", int'(hz16.ForwardAE), 1);
    chk("lit_fwdW_B", int'(hz16.ForwardBE), 1);
    cycle();

    // Both M and W write R5: M wins
    zeroIn(); hz16.WA3D = 4'd5; cycle();
    zeroIn(); hz16.WA3D = 4'd5; cycle();
    zeroIn(); hz16.RA1D = 4'd5; hz16.RA2D = 4'd6; cycle();
    zeroIn(); hz16.RegWriteM = 1'b1; hz16.RegWriteW = 1'b1;
    #1;
    chk("lit_prio_A", int'(hz16.ForwardAE), 2);
    chk("lit_prio_B", int'(hz16.ForwardBE), 0);
    cycle();

    // Load-use on R2
    zeroIn(); hz16.RA1D = 4'd1; hz16.RA2D = 4'd1; hz16.WA3D = 4'd2; cycle();
    zeroIn(); hz16.MemtoRegE = 1'b1; hz16.RA1D = 4'd1; hz16.RA2D = 4'd2;
    #1;
    c0 = int'(hz16.ldr_stall_cnt);
    chk("lit_lu_StallF", int'(hz16.StallF), 1);
    chk("lit_lu_StallD", int'(hz16.StallD), 1);
    chk("lit_lu_FlushE", int'(hz16.FlushE), 1);
    chk("lit_lu_FlushD", int'(hz16.FlushD), 0);
    cycle();
    #1;
    chk("lit_lu_nostall", int'(hz16.StallD), 0);
    chk("lit_lu_cnt", int'(hz16.ldr_stall_cnt), c0 + 1);
    cycle();

    // Branch taken
    zeroIn(); hz16.RA1D = 4'd8; hz16.BranchTakenE = 1'b1;
    #1;
    c0 = int'(hz16.br_flush_cnt);
    chk("lit_br_FlushD", int'(hz16.FlushD), 1);
    chk("lit_br_FlushE", int'(hz16.FlushE), 1);
    chk("lit_br_StallF", int'(hz16.StallF), 0);
    cycle();
    zeroIn(); hz16.RA1D = 4'd8;
    #1;
    chk("lit_br_cnt", int'(hz16.br_flush_cnt), c0 + 1);
    cycle();

    // PC write pending for three cycles
    for (int i = 0; i < 3; i++) begin
      zeroIn(); hz16.RA1D = 4'd9; hz16.PCWrPendingF = 1'b1;
      #1;
      chk("lit_pcw_StallF", int'(hz16.StallF), 1);
      chk("lit_pcw_FlushD", int'(hz16.FlushD), 1);
      chk("lit_pcw_FlushE", int'(hz16.FlushE), 0);
      cycle();
    end
    zeroIn(); hz16.RA1D = 4'd9; hz16.PCSrcW = 1'b1;
    #1;
    chk("lit_pcs_FlushD", int'(hz16.FlushD), 1);
    cycle();

    // Saturation of the 2-bit counter, then clear against a concurrent event
    zeroIn(); hz16.clr_cnt = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      zeroIn(); hz16.MemtoRegE = 1'b1; cycle();
    end
    zeroIn();
    #1;
    chk("lit_sat_cnt2", int'(hz2.ldr_stall_cnt), 3);
    chk("lit_sat_cnt16", int'(hz16.ldr_stall_cnt), 5);
    zeroIn(); hz16.MemtoRegE = 1'b1; hz16.BranchTakenE = 1'b1; hz16.clr_cnt = 1'b1;
    cycle();
    zeroIn();
    #1;
    chk("lit_clr_ldr2", int'(hz2.ldr_stall_cnt), 0);
    chk("lit_clr_ldr16", int'(hz16.ldr_stall_cnt), 0);
    chk("lit_clr_br16", int'(hz16.br_flush_cnt), 0);
    cycle();

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      setIn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
      if ($urandom_range(0, 300) == 0) begin
        rst_n = 1'b0;
        modelReset();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard detection and forwarding block for the 5-stage pipelined ARM core. It is the consumer end of the control unit's hazard interface. It takes RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW and BranchTakenE, plus register addresses from the Decode stage. It returns FlushE, the remaining stall/flush controls, and the ALU operand forwarding selects. It keeps its own E/M/W copies of the register addresses and saturating hazard event counters.

Parameters:
CNT_W, 16, width of each hazard event counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
RA1D  in  4  Decode source register 1 address
RA2D  in  4  Decode source register 2 address
WA3D  in  4  Decode destination register address (InstrD[15:12])
RegWriteM  in  1  Memory-stage gated register write
RegWriteW  in  1  Writeback-stage register write
MemtoRegE  in  1  Execute-stage instruction is a load
PCWrPendingF  in  1  PC write in flight in D/E/M
PCSrcW  in  1  PC write in Writeback
BranchTakenE  in  1  branch resolved taken in Execute
clr_cnt  in  1  synchronous clear of both counters
ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding as ForwardAE
StallF  out  1  hold PC register
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register (to control unit and datapath)
ldr_stall_cnt  out  CNT_W  cycles with a load-use stall
br_flush_cnt  out  CNT_W  cycles with BranchTakenE asserted

Behaviour:
- Reset (reset = 0, asynchronous):
  - RA1E, RA2E, WA3E, WA3M, WA3W <= 0.
  - Both counters <= 0.
  - Combinational outputs follow from the reset state and the current inputs. With all inputs 0, every output is 0.
- Internal address pipeline, updated on the rising edge:
  - {RA1E, RA2E, WA3E} <= FlushE ? 0 : {RA1D, RA2D, WA3D}.
  - WA3M <= WA3E; WA3W <= WA3M.
  - The E-stage registers are never stalled; they mirror the control unit's D/E register.
- Forwarding (combinational, same cycle):
  - ForwardAE = 10 if (RA1E == WA3M) & RegWriteM.
  - Else ForwardAE = 01 if (RA1E == WA3W) & RegWriteW.
  - Else ForwardAE = 00.
  - M has priority over W (most recent producer wins).
  - ForwardBE uses the same rule with RA2E.
- Load-use stall: LDRstall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)).
- Stall and flush equations:
  - StallF = LDRstall | PCWrPendingF.
  - StallD = LDRstall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Simultaneous LDRstall and BranchTakenE: both flushes assert. The branch wins: F/D is flushed while also stalled, and the flush takes precedence in the datapath register.
- Counters (rising edge, when reset = 1):
  - clr_cnt = 1 forces both counters to 0 and has priority over any increment in the same cycle.
  - Otherwise ldr_stall_cnt increments when LDRstall = 1.
  - Otherwise br_flush_cnt increments when BranchTakenE = 1.
  - Both saturate at 2^CNT_W - 1 with no wrap.
- Latency: all control outputs are combinational from the inputs and internal registers. Counters reflect an event one cycle after it occurs.
- Reset mid-operation clears the address pipeline immediately. Stale forwards cannot occur after reset, because RegWriteM and RegWriteW are also reset in the control unit.

Decomposition:
- Shared package core_pkg:
  - fwd_sel_t enum {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10}.
  - REG_AW = 4.
  - PC_REG = 4'd15.
- One natural sub-module: sat_counter (parameterised CNT_W, inc, clr, async active-low reset), instantiated twice.

Test Plan:
- Reset: assert reset = 0 with random inputs, release -> ForwardAE = ForwardBE = 00 and both counters = 0 immediately; with all inputs 0, StallF, StallD, FlushD, FlushE = 0.
- M-stage forward: ADD R3 in D, then a consumer with RA1D = 3, RA2D = 3 two cycles later with RegWriteM = 1 -> ForwardAE = ForwardBE = 10. Repeat with the consumer one cycle later (R3 now in W, RegWriteW = 1) -> 01.
- M/W priority: WA3M = WA3W = 5, RA1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10.
- Load-use: LDR R2 enters E (MemtoRegE = 1, WA3E = 2), RA2D = 2 -> StallF = StallD = FlushE = 1 for one cycle, ldr_stall_cnt goes 0 -> 1. The next cycle RA2E = 0 (flushed) and no stall.
- Branch and PC write: BranchTakenE = 1 -> FlushD = FlushE = 1 and br_flush_cnt increments. PCWrPendingF = 1 for 3 cycles -> StallF = FlushD = 1 each cycle, FlushE = 0.
- Counter saturation and clear: CNT_W = 2, 5 load-use events -> ldr_stall_cnt = 3. Then clr_cnt = 1 concurrent with another event -> 0.
